attack_timeline_controller: RTL and testbench
=============================================

// Module: attack_timeline_controller
// PURPOSE
//  Stage sequencer directly upstream of the attack-object ROM reader.
//  - Owns the stage clock (current_time, in ticks) and the ROM address pointer.
//  - Handshakes with the reader over sync_attack_time / update_attack_time.
//  - Releases the next attack entry only once its scheduled time is reached and
//    the position stage has acknowledged the previous object.
// PARAMETERS
//  ADDR_WIDTH     10          ROM address width; matches the reader.
//  MAXIMUM_TIMES  30          width of current_time / next_attack_time.
//  CLK_FREQ_HZ    25_000_000  clk frequency.
//  TICK_HZ        100         current_time increment rate (10 ms/tick).
//  END_TYPE       5'h1F       attack_types value marking end of stage.
// PORTS
//  clk                   in   1              system clock
//  reset_n               in   1              asynchronous, active-low reset
//  start                 in   1              pulse: begin stage from addr 0
//  stop                  in   1              pulse: abort to IDLE
//  pause                 in   1              level: freeze current_time
//  update_attack_time    in   1              reader: next_attack_time valid
//  next_attack_time      in   MAXIMUM_TIMES  reader: release time of entry
//  attack_types          in   5              reader: type of fetched entry
//  sync_attack_position  in   1              1 = position stage idle/acked
//  addr                  out  ADDR_WIDTH     ROM entry index
//  current_time          out  MAXIMUM_TIMES  stage time in ticks
//  sync_attack_time      out  1              0 = reader may fetch; 1 = hold
//  busy                  out  1              stage running (FETCH/WAIT)
//  stage_done            out  1              one-cycle pulse at stage end
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE, addr=0, current_time=0, prescaler=0.
//   - sync_attack_time=1, busy=0, stage_done=0, next_time_q=0.
//  Prescaler:
//   - Counts 0..CLK_FREQ_HZ/TICK_HZ-1 while busy && !pause.
//   - On wrap, current_time+1; saturates at all-ones (no wrap).
//   - pause holds both prescaler and current_time.
//  States:
//   - IDLE: sync=1. start -> addr=0, current_time=0, prescaler=0, sync=0, ->FETCH.
//   - FETCH: sync=0. On update_attack_time=1, latch next_time_q and type; sync=1
//     next edge.
//       * type==END_TYPE -> DONE.
//       * otherwise -> WAIT.
//   - WAIT: sync=1. When current_time>=next_time_q (unsigned) AND
//     sync_attack_position=1:
//       * addr!=LAST (all-ones) -> addr+1, sync=0, ->FETCH (same edge).
//       * addr==LAST -> DONE.
//   - DONE: stage_done=1 for exactly one cycle, sync=1, ->IDLE; addr/current_time held.
//  Latency:
//   - WAIT release -> sync falls on the same edge as addr increments.
//   - Reader returns update_attack_time 2 clocks later; sync rises 1 clock after that.
//  Priority and edge cases:
//   - stop beats start and all transitions: ->IDLE, sync=1, busy=0, no stage_done.
//   - start while busy is ignored.
//   - update_attack_time outside FETCH is ignored.
//   - next_time_q already <= current_time releases on the first WAIT cycle.
//   - pause does not block handshakes; WAIT only waits longer.
//  busy=1 exactly in FETCH and WAIT.
// CONFIGURATION
//  ATTACK_TIMELINE_LOOP_EN
//   - Defined: WAIT release at addr==LAST wraps addr to 0, clears current_time and
//     prescaler, sync=0, ->FETCH. stage_done still pulses once per wrap.
//     END_TYPE still ends the stage.
//   - Undefined: addr==LAST release -> DONE (no wrap).
// TESTING (CLK_FREQ_HZ=10, TICK_HZ=1 => 1 tick per 10 clk)
//  1. reset_n=0 mid-WAIT -> addr=0, time=0, sync=1, busy=0, stage_done=0
//     immediately (asynchronous).
//  2. start; reader model returns next=3 after 2 clk -> sync=1; sync falls at
//     time 3 (clk 30); addr=1.
//  3. next=5, sync_attack_position=0 until time 8 -> addr increments at time 8,
//     not at time 5.
//  4. pause held 40 clk during WAIT (next=2, start at time 0) -> release at time 2,
//     40 clk later than unpaused.
//  5. attack_types=5'h1F on entry 4 -> DONE; stage_done one pulse; addr stays 4;
//     sync=1.
//  6. ADDR_WIDTH=2, no END_TYPE -> DONE after addr 3.
//     With ATTACK_TIMELINE_LOOP_EN: addr 3 -> 0 and time=0.
//     stop during FETCH -> IDLE, no stage_done.

Source files
------------

// File: rtl/attack_timeline_controller.sv
// Stage sequencer ahead of the attack-object ROM reader: owns stage time and ROM address.
// Define ATTACK_TIMELINE_LOOP_EN to wrap from the last address back to entry 0 instead of ending.
module attack_timeline_controller #(
    parameter int         ADDR_WIDTH    = 10,
    parameter int         MAXIMUM_TIMES = 30,
    parameter int         CLK_FREQ_HZ   = 25_000_000,
    parameter int         TICK_HZ       = 100,
    parameter logic [4:0] END_TYPE      = 5'h1F
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    input  logic                     update_attack_time,
    input  logic [MAXIMUM_TIMES-1:0] next_attack_time,
    input  logic [4:0]               attack_types,
    input  logic                     sync_attack_position,
    output logic [ADDR_WIDTH-1:0]    addr,
    output logic [MAXIMUM_TIMES-1:0] current_time,
    output logic                     sync_attack_time,
    output logic                     busy,
    output logic                     stage_done
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]            PRE_MAX   = PW'(DIV - 1);
    localparam logic [ADDR_WIDTH-1:0]    ADDR_LAST = '1;
    localparam logic [MAXIMUM_TIMES-1:0] TIME_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [MAXIMUM_TIMES-1:0] time_q, time_d;
    logic [MAXIMUM_TIMES-1:0] next_time_q, next_time_d;
    logic [PW-1:0]            pre_q, pre_d;
    logic                     sync_q, sync_d;
    logic                     done_q, done_d;
    logic                     running;
    logic                     tick;
    logic                     release_ok;

    always_comb begin
        running     = (state_q == S_FETCH) || (state_q == S_WAIT);
        tick        = running && !pause && (pre_q == PRE_MAX);
        release_ok  = (time_q >= next_time_q) && sync_attack_position;
        state_d     = state_q;
        addr_d      = addr_q;
        time_d      = time_q;
        pre_d       = pre_q;
        next_time_d = next_time_q;
        done_d      = 1'b0;

        // Stage clock: frozen by pause, saturates instead of wrapping
        if (running && !pause) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick && (time_q != TIME_MAX)) begin
                time_d = time_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                    time_d  = '0;
                    pre_d   = '0;
                end
            end
            S_FETCH: begin
                if (update_attack_time) begin
                    next_time_d = next_attack_time;
                    if (attack_types == END_TYPE) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (release_ok) begin
                    if (addr_q != ADDR_LAST) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        done_d = 1'b1;
`ifdef ATTACK_TIMELINE_LOOP_EN
                        addr_d  = '0;
                        time_d  = '0;
                        pre_d   = '0;
                        state_d = S_FETCH;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stop) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end

        // Reader may fetch only while the next state is FETCH
        sync_d = (state_d != S_FETCH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            time_q      <= '0;
            pre_q       <= '0;
            next_time_q <= '0;
            sync_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            time_q      <= time_d;
            pre_q       <= pre_d;
            next_time_q <= next_time_d;
            sync_q      <= sync_d;
            done_q      <= done_d;
        end
    end

    assign addr             = addr_q;
    assign current_time     = time_q;
    assign sync_attack_time = sync_q;
    assign busy             = running;
    assign stage_done       = done_q;

endmodule

// File: tb/tb_attack_timeline_controller.sv
// Scoreboard bench for attack_timeline_controller: planned release events vs. a monitor.
// 1 tick per 10 clk, 3-bit addresses, 6-bit saturating stage time.
module tb_attack_timeline_controller;

    localparam int AW   = 3;
    localparam int TW   = 6;
    localparam int LAST = 7;
    localparam int ENDT = 31;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          stop;
    logic          pause;
    logic          update_attack_time;
    logic [TW-1:0] next_attack_time;
    logic [4:0]    attack_types;
    logic          sync_attack_position;
    logic [AW-1:0] addr;
    logic [TW-1:0] current_time;
    logic          sync_attack_time;
    logic          busy;
    logic          stage_done;

    attack_timeline_controller #(
        .ADDR_WIDTH   (AW),
        .MAXIMUM_TIMES(TW),
        .CLK_FREQ_HZ  (10),
        .TICK_HZ      (1),
        .END_TYPE     (5'h1F)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (start),
        .stop                (stop),
        .pause               (pause),
        .update_attack_time  (update_attack_time),
        .next_attack_time    (next_attack_time),
        .attack_types        (attack_types),
        .sync_attack_position(sync_attack_position),
        .addr                (addr),
        .current_time        (current_time),
        .sync_attack_time    (sync_attack_time),
        .busy                (busy),
        .stage_done          (stage_done)
    );

    typedef struct {
        int kind;
        int addr;
        int tm;
        int sy;
    } ev_t;

    int  checks = 0;
    int  errors = 0;
    int  ent_next[32];
    int  ent_gate[32];
    int  ent_type[32];
    int  n_fetch = 0;
    int  cur_gate = 0;
    bit  pos_hold = 0;
    ev_t sbq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, want);
        end
    endtask

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    task automatic set_ent(input int k, input int nx, input int gt, input int ty);
        ent_next[k] = nx;
        ent_gate[k] = gt;
        ent_type[k] = ty;
    endtask

    // Expected events: release time is the later of entry time, position ack and previous release
    task automatic plan_stage();
        int p;
        int a;
        p = 0;
        a = 0;
        sbq.push_back('{0, 0, 0, 0});
        for (int k = 0; k < 32; k++) begin
            if (ent_type[k] == ENDT) begin
                sbq.push_back('{1, a, 0, 1});
                return;
            end
            if (a == LAST) begin
`ifdef ATTACK_TIMELINE_LOOP_EN
                sbq.push_back('{1, LAST, 0, 0});
                sbq.push_back('{0, 0, 0, 0});
                a = 0;
                p = 0;
`else
                sbq.push_back('{1, LAST, 0, 1});
                return;
`endif
            end else begin
                p = max3(ent_next[k], ent_gate[k], p);
                a++;
                sbq.push_back('{0, a, p, 0});
            end
        end
    endtask

    // Random entries; never two zero-delta releases back to back
    task automatic gen_stage(input int end_idx);
        int p;
        int a;
        int z;
        int rel;
        p = 0;
        a = 0;
        z = 0;
        for (int k = 0; k < 32; k++) begin
            ent_type[k] = (k == end_idx) ? ENDT : int'($urandom_range(0, 30));
            ent_next[k] = p + (z != 0 ? int'($urandom_range(1, 3))
                                      : int'($urandom_range(0, 3)));
            ent_gate[k] = ($urandom_range(0, 1) != 0) ? 0
                          : p + int'($urandom_range(0, 3));
            rel = max3(ent_next[k], ent_gate[k], p);
            if (a == LAST) begin
                a = 0;
                p = 0;
                z = 0;
            end else begin
                a++;
                z = (rel == p) ? 1 : 0;
                p = rel;
            end
        end
    endtask

    // ROM reader: answers a fetch request two clocks later
    initial begin
        update_attack_time = 1'b0;
        next_attack_time   = '0;
        attack_types       = '0;
        forever begin
            @(negedge clk);
            if (reset_n && busy && !sync_attack_time) begin
                int idx;
                idx = n_fetch % 32;
                n_fetch++;
                @(negedge clk);
                update_attack_time = 1'b1;
                next_attack_time   = TW'(ent_next[idx]);
                attack_types       = 5'(ent_type[idx]);
                cur_gate           = ent_gate[idx];
                @(negedge clk);
                update_attack_time = 1'b0;
            end
        end
    end

    // Position stage: acknowledges once the stage time reaches the entry's gate
    initial begin
        sync_attack_position = 1'b0;
        forever begin
            @(negedge clk);
            sync_attack_position = !pos_hold && (int'(current_time) >= cur_gate);
        end
    end

    // Monitor
    initial begin
        bit  prev_sync;
        ev_t e;
        prev_sync = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_sync = 1'b1;
            end else begin
                if (stage_done) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_stage_done", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("done_kind", 1, e.kind);
                        chk("done_addr", int'(addr), e.addr);
                        chk("done_sync", int'(sync_attack_time), e.sy);
                        chk("done_busy", int'(busy), 1 - e.sy);
                    end
                end
                if (prev_sync && !sync_attack_time) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_fetch", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("fetch_kind", 0, e.kind);
                        chk("fetch_addr", int'(addr), e.addr);
                        chk("fetch_time", int'(current_time), e.tm);
                    end
                end
                prev_sync = sync_attack_time;
            end
        end
    end

    task automatic run_stage(input bit rnd);
        int cnt;
        int hold;
        n_fetch = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt   = 0;
        hold  = 0;
        while (busy && cnt < 4000) begin
            if (rnd) begin
                if ($urandom_range(0, 7) == 0) pause = ~pause;
                start = ($urandom_range(0, 19) == 0);
            end
            if (pos_hold && (int'(current_time) == 63)) begin
                hold++;
                if (hold >= 30) pos_hold = 0;
            end
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        pause = 1'b0;
        if (cnt >= 4000) chk("stage_timeout", cnt, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_timed(input int pause_at, input int pause_len, output int cyc);
        int cnt;
        n_fetch = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt   = 1;
        while (int'(addr) != 1 && cnt < 500) begin
            if (cnt == 2) chk("sync_in_fetch", int'(sync_attack_time), 0);
            if (cnt == 3) chk("sync_after_update", int'(sync_attack_time), 1);
            if (cnt == pause_at) pause = 1'b1;
            if (cnt == pause_at + pause_len) pause = 1'b0;
            @(negedge clk);
            cnt++;
        end
        pause = 1'b0;
        cyc   = cnt;
        cnt   = 0;
        while (busy && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 500) chk("timed_stage_timeout", cnt, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int cnt;
        start   = 1'b0;
        stop    = 1'b0;
        pause   = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_addr", int'(addr), 0);
        chk("rst_time", int'(current_time), 0);
        chk("rst_sync", int'(sync_attack_time), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(stage_done), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        set_ent(0, 3, 0, 1);
        set_ent(1, 0, 0, ENDT);
        plan_stage();
        run_stage(0);

        set_ent(0, 5, 8, 2);
        set_ent(1, 0, 0, ENDT);
        plan_stage();
        run_stage(0);

        set_ent(0, 2, 0, 3);
        set_ent(1, 0, 0, ENDT);
        plan_stage();
        run_timed(-100, 0, c);
        chk("release_cycles_unpaused", c, 22);
        plan_stage();
        run_timed(3, 40, c);
        chk("release_cycles_paused", c, 62);

        for (int k = 0; k < 4; k++) set_ent(k, k + 1, 0, 4);
        set_ent(4, 0, 0, ENDT);
        plan_stage();
        run_stage(0);

`ifdef ATTACK_TIMELINE_LOOP_EN
        gen_stage(10);
`else
        gen_stage(-1);
`endif
        plan_stage();
        run_stage(0);

        set_ent(0, 5, 0, 1);
        set_ent(1, 0, 0, ENDT);
        sbq.push_back('{0, 0, 0, 0});
        n_fetch = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_sync", int'(sync_attack_time), 1);
        chk("stop_busy", int'(busy), 0);
        repeat (6) @(negedge clk);
        chk("stop_stays_idle", int'(busy), 0);

        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("stop_beats_start_busy", int'(busy), 0);
        chk("stop_beats_start_sync", int'(sync_attack_time), 1);
        repeat (2) @(negedge clk);

        set_ent(0, 1, 0, 1);
        set_ent(1, 20, 0, 1);
        set_ent(2, 0, 0, ENDT);
        plan_stage();
        n_fetch = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt   = 0;
        while (!(int'(addr) == 1 && sync_attack_time && busy) && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 400) chk("reach_wait_timeout", cnt, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_addr", int'(addr), 0);
        chk("async_rst_time", int'(current_time), 0);
        chk("async_rst_sync", int'(sync_attack_time), 1);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(stage_done), 0);
        sbq.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        set_ent(0, 63, 0, 1);
        set_ent(1, 0, 0, ENDT);
        pos_hold = 1;
        plan_stage();
        run_stage(0);
        pos_hold = 0;

        repeat (25) begin
`ifdef ATTACK_TIMELINE_LOOP_EN
            gen_stage(int'($urandom_range(0, 15)));
`else
            gen_stage(($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 7)));
`endif
            plan_stage();
            run_stage(1);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
